// File: rtl/viterbi_pkg.sv
// Shared defaults, trellis-state type and traceback FSM encoding for the Viterbi traceback path.
// Latency: none (declarations only).
// Backpressure: none (declarations only). Optional UNLOAD state exists only with TB_REVERSE_EN.
package viterbi_pkg;

  localparam int DEFAULT_STATE_W    = 3;
  localparam int DEFAULT_DATA_WIDTH = 2 ** DEFAULT_STATE_W;
  localparam int DEFAULT_ADDR_WIDTH = 6;

  typedef logic [DEFAULT_STATE_W-1:0] trellis_state_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3
`ifdef TB_REVERSE_EN
    ,
    UNLOAD = 3'd4
`endif
  } tb_fsm_t;

endpackage

// File: rtl/tb_lifo.sv
// Bit LIFO (depth 2**ADDR_WIDTH-1) that reverses traceback output order; present only with TB_REVERSE_EN.
// Latency: pushed bit is visible on top_bit the cycle after the push.
// Backpressure: none; pushes when full and pops when empty are dropped, the caller never exceeds depth.
`ifdef TB_REVERSE_EN
module tb_lifo #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_bit,
  input  logic pop,
  output logic top_bit,
  output logic last
);

  localparam int DEPTH = 2 ** ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] FULL = ADDR_WIDTH'(DEPTH);

  logic [DEPTH-1:0]      mem_q, mem_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;

  // Push writes at the fill level; pop only lowers the fill level.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (push && (count_q != FULL)) begin
      mem_d[count_q] = push_bit;
      count_d        = count_q + ONE;
    end else if (pop && (count_q != '0)) begin
      count_d = count_q - ONE;
    end
  end

  assign top_bit = mem_q[count_q - ONE];
  assign last    = (count_q == ONE);

  // Storage and fill level; reset empties the stack.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/traceback_unit.sv
// Viterbi traceback: walks tb_len survivor words backwards from end_addr emitting one decoded bit per stage.
// Latency: first bit_valid 3 cycles after start (tb_len+3 with TB_REVERSE_EN), done one cycle after last bit.
// Backpressure: none; one stage per clock, start is ignored while busy or done is high.
module traceback_unit
  import viterbi_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int STATE_W    = DEFAULT_STATE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic [ADDR_WIDTH-1:0] tb_len,
  input  logic [STATE_W-1:0]    start_state,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  tb_fsm_t               fsm_q, fsm_d;
  logic [STATE_W-1:0]    path_q, path_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  bit_out_q, bit_out_d;
  logic                  bit_valid_q, bit_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  surv_bit;

  // Survivor decision of the current trellis state; the word arrives one cycle after its address.
  assign surv_bit = rd_data[path_q];

`ifdef TB_REVERSE_EN
  logic push, pop, lifo_top, lifo_last;

  tb_lifo #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_lifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_bit(path_q[STATE_W-1]),
    .pop     (pop),
    .top_bit (lifo_top),
    .last    (lifo_last)
  );
`endif

  // Next-state and datapath: PRIME covers the store read latency, RUN retires one stage per clock.
  always_comb begin
    fsm_d       = fsm_q;
    path_d      = path_q;
    rd_addr_d   = rd_addr_q;
    cnt_d       = cnt_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    done_d      = 1'b0;
`ifdef TB_REVERSE_EN
    push        = 1'b0;
    pop         = 1'b0;
`endif
    case (fsm_q)
      IDLE: begin
        // done_q high means the previous traceback's completion cycle; its start is not a new request.
        if (start && !done_q) begin
          path_d    = start_state;
          rd_addr_d = end_addr;
          cnt_d     = tb_len;
          fsm_d     = (tb_len == '0) ? DONE : PRIME;
        end
      end
      PRIME: begin
        rd_addr_d = rd_addr_q - ONE;
        fsm_d     = RUN;
      end
      RUN: begin
        path_d    = {path_q[STATE_W-2:0], surv_bit};
        rd_addr_d = rd_addr_q - ONE;
        cnt_d     = cnt_q - ONE;
`ifdef TB_REVERSE_EN
        push = 1'b1;
        if (cnt_q == ONE) fsm_d = UNLOAD;
`else
        bit_out_d   = path_q[STATE_W-1];
        bit_valid_d = 1'b1;
        if (cnt_q == ONE) fsm_d = DONE;
`endif
      end
`ifdef TB_REVERSE_EN
      UNLOAD: begin
        pop         = 1'b1;
        bit_out_d   = lifo_top;
        bit_valid_d = 1'b1;
        if (lifo_last) fsm_d = DONE;
      end
`endif
      DONE: begin
        done_d = 1'b1;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
    busy_d = (fsm_d != IDLE);
  end

  // State and output registers; reset aborts any traceback in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= IDLE;
      path_q      <= '0;
      rd_addr_q   <= '0;
      cnt_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      path_q      <= path_d;
      rd_addr_q   <= rd_addr_d;
      cnt_q       <= cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_traceback_unit.sv
// Testbench for traceback_unit: survivor store model with one-cycle read, reference traceback computed per stage.
// Latency: checks bit timing relative to the start cycle.
// Backpressure: none exercised; start re-pulses and resets are injected at chosen cycles.
module tb_traceback_unit;
  import viterbi_pkg::*;

  localparam int AW = DEFAULT_ADDR_WIDTH;
  localparam int DW = DEFAULT_DATA_WIDTH;
  localparam int SW = DEFAULT_STATE_W;
  localparam int NA = 2 ** AW;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [AW-1:0]  end_addr;
  logic [AW-1:0]  tb_len;
  trellis_state_t start_state;
  logic [AW-1:0]  rd_addr;
  logic [DW-1:0]  rd_data;
  logic           bit_out, bit_valid, busy, done;

  logic [DW-1:0]  mem [NA];
  int checks = 0;
  int errors = 0;
  int exp_bits[$];
  int got_bits[$];
  int got_cyc[$];

  always #5 clk = ~clk;

  // Survivor store: registered read, word valid one clock after its address.
  always @(posedge clk) rd_data <= mem[rd_addr];

  traceback_unit #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .STATE_W   (SW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .end_addr   (end_addr),
    .tb_len     (tb_len),
    .start_state(start_state),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < NA; i++) begin
      if (mode == 0) mem[i] = '0;
      else if (mode == 1) mem[i] = '1;
      else mem[i] = DW'($urandom());
    end
  endtask

  // Reference: state s emits its MSB, then becomes (s<<1 | decision[s]) reading one address lower each stage.
  task automatic build_expected(input int ea, input int len, input int ss);
    int s, a, b;
    exp_bits.delete();
    s = ss;
    for (int i = 0; i < len; i++) begin
      b = (s >> (SW - 1)) & 1;
`ifdef TB_REVERSE_EN
      exp_bits.push_front(b);
`else
      exp_bits.push_back(b);
`endif
      a = (ea - i) & (NA - 1);
      s = ((s << 1) | int'(mem[a][s])) & (NA'(0) + (2 ** SW - 1));
    end
  endtask

  task automatic do_trace(input string tag, input int ea, input int len, input int ss,
                          input int restart_at, input int reset_at, input bit want_addr);
    int addr_seen[8];
    int done_n, done_at, first_exp, done_exp, stop_rel, n_exp;
    build_expected(ea, len, ss);
`ifdef TB_REVERSE_EN
    first_exp = len + 3;
    done_exp  = (len == 0) ? 2 : 2 * len + 3;
`else
    first_exp = 3;
    done_exp  = (len == 0) ? 2 : len + 3;
`endif
    stop_rel = (reset_at >= 0) ? reset_at + 8 : done_exp + 4;
    got_bits.delete();
    got_cyc.delete();
    done_n  = 0;
    done_at = -1;
    @(negedge clk);
    start       = 1'b1;
    end_addr    = ea[AW-1:0];
    tb_len      = len[AW-1:0];
    start_state = ss[SW-1:0];
    for (int rel = 1; rel <= stop_rel; rel++) begin
      @(negedge clk);
      start = (rel == restart_at);
      reset = (rel == reset_at);
      if (bit_valid) begin
        got_bits.push_back(int'(bit_out));
        got_cyc.push_back(rel);
      end
      if (done) begin
        done_n++;
        done_at = rel;
      end
      if (rel < 8) addr_seen[rel] = int'(rd_addr);
      if (rel == 1 && len > 0) check({tag, ".busy_first"}, 32'(busy), 32'd1);
      if (reset_at >= 0 && rel == reset_at + 1) begin
        check({tag, ".rst_valid"}, 32'(bit_valid), 32'd0);
        check({tag, ".rst_bit"},   32'(bit_out),   32'd0);
        check({tag, ".rst_busy"},  32'(busy),      32'd0);
        check({tag, ".rst_done"},  32'(done),      32'd0);
        check({tag, ".rst_addr"},  32'(rd_addr),   32'd0);
      end
      if (reset_at < 0 && rel == done_exp + 1) check({tag, ".busy_after"}, 32'(busy), 32'd0);
    end
    start = 1'b0;
    reset = 1'b0;

    if (reset_at < 0) n_exp = len;
    else begin
      n_exp = reset_at - first_exp + 1;
      if (n_exp < 0) n_exp = 0;
      if (n_exp > len) n_exp = len;
    end
    check({tag, ".count"}, 32'(got_bits.size()), 32'(n_exp));
    for (int i = 0; i < got_bits.size() && i < n_exp; i++)
      check($sformatf("%s.bit%0d", tag, i), 32'(got_bits[i]), 32'(exp_bits[i]));
    if (got_bits.size() > 0 && n_exp > 0) begin
      check({tag, ".first_cyc"}, 32'(got_cyc[0]), 32'(first_exp));
      check({tag, ".last_cyc"}, 32'(got_cyc[got_cyc.size()-1]), 32'(first_exp + got_bits.size() - 1));
    end
    check({tag, ".done_n"}, 32'(done_n), (reset_at < 0) ? 32'd1 : 32'd0);
    if (reset_at < 0) check({tag, ".done_cyc"}, 32'(done_at), 32'(done_exp));
    if (want_addr)
      for (int k = 1; k <= 5; k++)
        check($sformatf("%s.addr%0d", tag, k), 32'(addr_seen[k]), 32'((ea - (k - 1)) & (NA - 1)));
  endtask

  initial begin
    int ref030[5];
    int ea, len, ss;
    reset = 1'b1;
    start = 1'b0;
    end_addr = '0;
    tb_len = '0;
    start_state = '0;
    fill(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.rd_addr",   32'(rd_addr),   32'd0);
    check("reset.bit_out",   32'(bit_out),   32'd0);
    check("reset.bit_valid", 32'(bit_valid), 32'd0);
    check("reset.busy",      32'(busy),      32'd0);
    check("reset.done",      32'(done),      32'd0);
    reset = 1'b0;

    // All-zero store from state 0.
    fill(0);
    do_trace("zeros", 10, 5, 0, -1, -1, 1'b0);

    // All-ones store: states 000,001,011,111,111.
    fill(1);
    do_trace("ones", 20, 5, 0, -1, -1, 1'b0);
`ifdef TB_REVERSE_EN
    ref030 = '{1, 1, 0, 0, 0};
`else
    ref030 = '{0, 0, 0, 1, 1};
`endif
    for (int i = 0; i < 5 && i < got_bits.size(); i++)
      check($sformatf("ones.const%0d", i), 32'(got_bits[i]), 32'(ref030[i]));

    // Address wrap below zero.
    fill(2);
    do_trace("wrap", 2, 5, 5, -1, -1, 1'b1);

    // Zero-length traceback.
    do_trace("len0", 7, 0, 3, -1, -1, 1'b0);

    // Start re-pulsed mid-run and in the done cycle.
    do_trace("restart_run", 33, 6, 6, 4, -1, 1'b0);
`ifdef TB_REVERSE_EN
    do_trace("restart_done", 40, 3, 1, 9, -1, 1'b0);
`else
    do_trace("restart_done", 40, 3, 1, 6, -1, 1'b0);
`endif

    // Reset in the middle of a traceback, then a normal one.
    do_trace("abort", 50, 8, 7, -1, 3, 1'b0);
    do_trace("after_abort", 50, 8, 7, -1, -1, 1'b1);

    // Longest traceback wrapping from address 0.
    fill(2);
    do_trace("maxlen", 0, NA - 1, 2, -1, -1, 1'b1);

    // Random tracebacks.
    for (int it = 0; it < 10; it++) begin
      fill(2);
      ea  = int'($urandom_range(0, NA - 1));
      len = int'($urandom_range(1, NA - 1));
      ss  = int'($urandom_range(0, 2 ** SW - 1));
      do_trace($sformatf("rand%0d", it), ea, len, ss, -1, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
